// File: rtl/seven_seg_scan_mux.sv
// seven_seg_scan_mux: time-multiplexed scan controller feeding a BCD-to-7-segment
// decoder. Presents one digit per slot with guard time, one-hot common-pin enables,
// and tear-free value updates at frame boundaries.
// Optional feature: define SCAN_LZB_EN for leading-zero blanking via rbi.
module seven_seg_scan_mux #(
    parameter int DIGITS = 4,
    parameter int DIV    = 1000,
    parameter int GUARD  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_in,
    output logic                  load_ack,
    output logic [3:0]            bcd,
    output logic                  rbi,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_start
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_GLAST = CW'(GUARD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    typedef enum logic {PH_GUARD, PH_SHOW} phase_t;

    // cnt/idx/phase name the position registered into the outputs at the next edge,
    // so the outputs lag them by one clock; the frame edge is therefore cnt==0,idx==0,
    // which is the cycle in which the outputs still show the last slot's final clock.
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    phase_t              phase;
    logic [4*DIGITS-1:0] active, pending;
    logic                pend;

    logic                frame_edge;
    logic [4*DIGITS-1:0] active_nx, pending_nx;
    logic                pend_nx, ack_nx;
    logic [3:0]          nib;
    logic [DIGITS-1:0]   onehot;

    assign frame_edge = (cnt == '0) && (idx == '0);

    // Value hand-over: load at the frame edge bypasses pending; otherwise pending waits.
    always_comb begin
        active_nx  = active;
        pending_nx = pending;
        pend_nx    = pend;
        ack_nx     = 1'b0;
        if (frame_edge) begin
            if (load) begin
                active_nx = value_in;
                pend_nx   = 1'b0;
                ack_nx    = 1'b1;
            end else if (pend) begin
                active_nx = pending;
                pend_nx   = 1'b0;
                ack_nx    = 1'b1;
            end
        end else if (load) begin
            pending_nx = value_in;
            pend_nx    = 1'b1;
        end
    end

    // Digit nibble for the slot being entered (digit 0 is the MS nibble) and its enable.
    always_comb begin
        nib    = '0;
        onehot = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nib       = active_nx[4*(DIGITS-1-i) +: 4];
                onehot[i] = 1'b1;
            end
        end
    end

`ifdef SCAN_LZB_EN
    logic z, z_nx;

    // Blanking chain: restarts at digit 0, breaks at the first nonzero digit shown.
    always_comb begin
        z_nx = (idx == '0) ? 1'b1 : (z & (bcd == 4'd0));
    end
`endif

    // Slot counters, guard/show phase FSM and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            phase       <= PH_GUARD;
            active      <= '0;
            pending     <= '0;
            pend        <= 1'b0;
            bcd         <= '0;
            dig_en      <= '0;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
`ifdef SCAN_LZB_EN
            z           <= 1'b1;
            rbi         <= 1'b1;
`else
            rbi         <= 1'b0;
`endif
        end else begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            if (cnt == CNT_LAST)
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);

            case (phase)
                PH_GUARD: if (cnt == CNT_GLAST) phase <= PH_SHOW;
                PH_SHOW:  if (cnt == CNT_LAST)  phase <= PH_GUARD;
                default:  phase <= PH_GUARD;
            endcase

            dig_en      <= (phase == PH_SHOW) ? onehot : '0;
            frame_start <= frame_edge;
            load_ack    <= ack_nx;
            active      <= active_nx;
            pending     <= pending_nx;
            pend        <= pend_nx;

            if (cnt == '0) begin
                bcd <= nib;
`ifdef SCAN_LZB_EN
                z   <= z_nx;
                rbi <= z_nx && (idx != IDX_LAST);
`endif
            end
`ifndef SCAN_LZB_EN
            rbi <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Directed bench for seven_seg_scan_mux with DIGITS=4, DIV=8, GUARD=2.
// rbi expectations follow SCAN_LZB_EN.
module tb_seven_seg_scan_mux;

`ifdef SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value_in;
    logic        load_ack;
    logic [3:0]  bcd;
    logic        rbi;
    logic [3:0]  dig_en;
    logic        frame_start;

    int n_assert = 0;
    int n_fail   = 0;
    int pos      = 31;   // frame position (idx*8+cnt) currently shown on the outputs

    seven_seg_scan_mux #(.DIGITS(4), .DIV(8), .GUARD(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value_in   (value_in),
        .load_ack   (load_ack),
        .bcd        (bcd),
        .rbi        (rbi),
        .dig_en     (dig_en),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (pos %0d)", tag, obs, exp, pos);
        end
    endtask

    task automatic adv();
        @(negedge clk);
        pos = (pos + 1) % 32;
    endtask

    task automatic goto(input int target);
        while (pos != target) adv();
    endtask

    task automatic ld(input logic [15:0] v);
        load     = 1'b1;
        value_in = v;
        adv();
        load     = 1'b0;
        value_in = '0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_bcd"}, bcd, 0);
        chk({tag, "_rbi"}, rbi, LZB);
        chk({tag, "_dig_en"}, dig_en, 0);
        chk({tag, "_load_ack"}, load_ack, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
    endtask

    // One complete frame starting at the next frame_start; rb bit i = expected rbi of slot i.
    task automatic chk_frame(input logic [15:0] v, input logic [3:0] rb, input logic ack0);
        int ix, c;
        goto(31);
        for (int i = 0; i < 32; i++) begin
            adv();
            ix = pos / 8;
            c  = pos % 8;
            chk("bcd", bcd, (v >> (4 * (3 - ix))) & 16'hf);
            chk("rbi", rbi, rb[ix]);
            chk("dig_en", dig_en, (c < 2) ? 0 : (1 << ix));
            chk("frame_start", frame_start, (pos == 0) ? 1 : 0);
            chk("load_ack", load_ack, (pos == 0) ? ack0 : 1'b0);
        end
    endtask

    // Displayed value must stay the old one (no tearing) until pos reaches target.
    task automatic hold_old(input logic [15:0] v, input int target);
        while (pos != target) begin
            chk("hold_bcd", bcd, (v >> (4 * (3 - pos / 8))) & 16'hf);
            chk("hold_ack", load_ack, 0);
            adv();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        value_in = '0;
        #23;
        chk_reset("por");
        @(negedge clk);
        rst_n = 1'b1;
        pos   = 31;

        // Scan pattern after release, including the wrap into a second frame.
        chk_frame(16'h0000, LZB ? 4'b0111 : 4'b0000, 1'b0);
        chk_frame(16'h0000, LZB ? 4'b0111 : 4'b0000, 1'b0);

        // Leading zeros blanked, LS digit always shown.
        goto(5);
        ld(16'h0042);
        chk_frame(16'h0042, LZB ? 4'b0111 : 4'b0000, 1'b1);
        goto(10);
        ld(16'h0000);
        chk_frame(16'h0000, LZB ? 4'b0111 : 4'b0000, 1'b1);
        goto(3);
        ld(16'h1000);
        chk_frame(16'h1000, LZB ? 4'b0001 : 4'b0000, 1'b1);

        // Two loads in one frame: old value held, last load wins, single ack.
        goto(9);
        ld(16'h1234);
        hold_old(16'h1000, 17);
        ld(16'h5678);
        hold_old(16'h1000, 31);
        chk_frame(16'h5678, LZB ? 4'b0001 : 4'b0000, 1'b1);
        chk_frame(16'h5678, LZB ? 4'b0001 : 4'b0000, 1'b0);

        // Load in the boundary cycle goes straight to the display.
        goto(31);
        ld(16'h9999);
        chk("bypass_bcd", bcd, 4'h9);
        chk("bypass_ack", load_ack, 1);
        chk("bypass_fs", frame_start, 1);
        chk_frame(16'h9999, LZB ? 4'b0001 : 4'b0000, 1'b0);

        // Asynchronous reset mid-slot 2 discards the pending value.
        goto(5);
        ld(16'h4321);
        goto(20);
        chk("pre_rst_dig_en", dig_en, 4'b0100);
        rst_n = 1'b0;
        #1;
        chk_reset("async");
        @(negedge clk);
        chk_reset("held");
        rst_n = 1'b1;
        pos   = 31;
        chk_frame(16'h0000, LZB ? 4'b0111 : 4'b0000, 1'b0);
        chk_frame(16'h0000, LZB ? 4'b0111 : 4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
